// File: rtl/switch_toggle_bank_pkg.sv
// Shared definitions for the user-switch bank: LED mode encoding and counter sizing.
package switch_toggle_bank_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  // Bits needed to count from 0 up to max_val-1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One user-switch channel: 2-FF synchroniser, debounce filter, edge pulses and
// long-press detection on the debounced level.
module switch_debounce_channel
  import switch_toggle_bank_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Stable,
  output logic o_Release_Evt,
  output logic o_Press_Pulse,
  output logic o_Release_Pulse,
  output logic o_Long_Press
);

  localparam int DB_W   = cnt_width(DEBOUNCE_LIMIT);
  localparam int HOLD_W = cnt_width(LONG_PRESS_LIMIT + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_LIMIT);

  logic              sync_meta;
  logic              sync_lvl;
  logic              stable;
  logic              stable_d;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              press_evt;
  logic              release_evt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= i_Switch;
      sync_lvl  <= sync_meta;
    end
  end

  // Any sample agreeing with the accepted level restarts the stability count.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      db_cnt <= '0;
      stable <= 1'b0;
    end else if (sync_lvl == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      stable <= sync_lvl;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign press_evt   = stable & ~stable_d;
  assign release_evt = ~stable & stable_d;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      stable_d        <= 1'b0;
      o_Press_Pulse   <= 1'b0;
      o_Release_Pulse <= 1'b0;
    end else begin
      stable_d        <= stable;
      o_Press_Pulse   <= press_evt;
      o_Release_Pulse <= release_evt;
    end
  end

  // Hold time is counted from the cycle the press pulse is issued, so the
  // flag rises LONG_PRESS_LIMIT+1 cycles after that pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_cnt     <= '0;
      o_Long_Press <= 1'b0;
    end else begin
      if (!stable) begin
        hold_cnt <= '0;
      end else if (stable_d && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      o_Long_Press <= stable && (hold_cnt == HOLD_MAX);
    end
  end

  assign o_Stable      = stable;
  assign o_Release_Evt = release_evt;

endmodule

// File: rtl/switch_toggle_bank.sv
// Bank of NUM_CH debounced user switches driving LEDs in toggle or momentary mode.
// Each channel is filtered independently; this level owns toggle state, clear and LED muxing.
module switch_toggle_bank
  import switch_toggle_bank_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int DEBOUNCE_LIMIT   = 250000,
  parameter int LONG_PRESS_LIMIT = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  input  logic [NUM_CH-1:0] i_Mode,
  input  logic              i_Clear,
  output logic [NUM_CH-1:0] o_LED,
  output logic [NUM_CH-1:0] o_Press_Pulse,
  output logic [NUM_CH-1:0] o_Release_Pulse,
  output logic [NUM_CH-1:0] o_Long_Press
);

  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] release_evt;
  logic [NUM_CH-1:0] toggle_q;
  logic [NUM_CH-1:0] toggle_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    switch_debounce_channel #(
      .DEBOUNCE_LIMIT  (DEBOUNCE_LIMIT),
      .LONG_PRESS_LIMIT(LONG_PRESS_LIMIT)
    ) u_chan (
      .i_Clk          (i_Clk),
      .i_Rst_L        (i_Rst_L),
      .i_Switch       (i_Switch[g]),
      .o_Stable       (stable[g]),
      .o_Release_Evt  (release_evt[g]),
      .o_Press_Pulse  (o_Press_Pulse[g]),
      .o_Release_Pulse(o_Release_Pulse[g]),
      .o_Long_Press   (o_Long_Press[g])
    );
  end

  // Long presses are left to user logic and never flip the LED; toggle state
  // is frozen while a channel is in momentary mode. Clear overrides a release.
  always_comb begin
    toggle_nxt = toggle_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((i_Mode[i] == MODE_TOGGLE) && release_evt[i] && !o_Long_Press[i]) begin
        toggle_nxt[i] = ~toggle_q[i];
      end
    end
    if (i_Clear) begin
      toggle_nxt = '0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      toggle_q <= '0;
      o_LED    <= '0;
    end else begin
      toggle_q <= toggle_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        o_LED[i] <= (i_Mode[i] == MODE_MOMENTARY) ? stable[i] : toggle_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_switch_toggle_bank.sv
// Self-checking bench for switch_toggle_bank: directed table, corner sequences and
// randomized switch activity checked every cycle against a history-based model.
module tb_switch_toggle_bank;
  import switch_toggle_bank_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DL     = 4;
  localparam int LL     = 10;

  logic              i_Clk;
  logic              i_Rst_L;
  logic [NUM_CH-1:0] sw;
  logic [NUM_CH-1:0] mode;
  logic              clr;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] press_p;
  logic [NUM_CH-1:0] release_p;
  logic [NUM_CH-1:0] long_p;

  int n_checks = 0;
  int n_fail   = 0;

  switch_toggle_bank #(
    .NUM_CH(NUM_CH), .DEBOUNCE_LIMIT(DL), .LONG_PRESS_LIMIT(LL)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(sw), .i_Mode(mode), .i_Clear(clr),
    .o_LED(led), .o_Press_Pulse(press_p), .o_Release_Pulse(release_p), .o_Long_Press(long_p)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: a level is accepted once the last DL synchronised samples
  // (raw input delayed two clocks) all disagree with the current accepted level.
  logic [NUM_CH-1:0] hist[$];
  logic [NUM_CH-1:0] s0, s1, s2;
  logic [NUM_CH-1:0] e_press, e_release, e_long, e_toggle, e_led;
  logic [NUM_CH-1:0] in_press;
  int                press_edge[NUM_CH];
  int                edge_n = 0;

  task automatic model_reset();
    hist.delete();
    repeat (DL + 2) hist.push_back('0);
    s0 = '0; s1 = '0; s2 = '0;
    e_press = '0; e_release = '0; e_long = '0; e_toggle = '0; e_led = '0;
    in_press = '0;
    for (int c = 0; c < NUM_CH; c++) press_edge[c] = 0;
  endtask

  task automatic model_edge();
    logic [NUM_CH-1:0] nxt;
    logic [NUM_CH-1:0] long_before;
    edge_n++;
    hist.push_front(sw);
    void'(hist.pop_back());
    for (int c = 0; c < NUM_CH; c++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = 2; j < DL + 2; j++) if (hist[j][c] == s0[c]) all_diff = 1'b0;
      nxt[c] = all_diff ? ~s0[c] : s0[c];
    end
    s2 = s1; s1 = s0; s0 = nxt;
    e_press   = s1 & ~s2;
    e_release = ~s1 & s2;
    long_before = e_long;
    for (int c = 0; c < NUM_CH; c++) begin
      if (e_press[c]) begin
        in_press[c]   = 1'b1;
        press_edge[c] = edge_n;
      end
      if (e_release[c]) in_press[c] = 1'b0;
      e_long[c] = in_press[c] && ((edge_n - press_edge[c]) >= LL + 1);
      if (clr) e_toggle[c] = 1'b0;
      else if (e_release[c] && !long_before[c] && mode[c] == MODE_TOGGLE)
        e_toggle[c] = ~e_toggle[c];
      e_led[c] = (mode[c] == MODE_MOMENTARY) ? s1[c] : e_toggle[c];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    if (i_Rst_L) model_edge();
    #1;
    chk("model_led", 32'(led), 32'(e_led));
    chk("model_press", 32'(press_p), 32'(e_press));
    chk("model_release", 32'(release_p), 32'(e_release));
    chk("model_long", 32'(long_p), 32'(e_long));
  endtask

  task automatic reset_and_check(input logic [NUM_CH-1:0] v);
    sw = v; clr = 1'b0;
    i_Rst_L = 1'b0;
    model_reset();
    repeat (3) begin
      step();
      chk("reset_outputs_zero", 32'({led, press_p, release_p, long_p}), 32'h0);
    end
    i_Rst_L = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("reset_press_timing", 32'(press_p), (k == 7) ? 32'(v) : 32'h0);
      chk("reset_no_release", 32'(release_p), 32'h0);
    end
  endtask

  typedef struct {
    logic [NUM_CH-1:0] sw;
    logic [NUM_CH-1:0] mode;
    int                hold;
    logic [NUM_CH-1:0] exp_led;
    int                exp_press;
    int                exp_rel;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int got, cnt, prev_long, npress, nrel;
    sw = '0; mode = '0; clr = 1'b0; i_Rst_L = 1'b0;
    model_reset();

    tbl.push_back('{4'b0000, 4'b0000, 10, 4'b0000, 0, 0});
    tbl.push_back('{4'b0001, 4'b0000,  8, 4'b0000, 1, 0});
    tbl.push_back('{4'b0000, 4'b0000, 10, 4'b0001, 0, 1});
    tbl.push_back('{4'b0001, 4'b0000,  8, 4'b0001, 1, 0});
    tbl.push_back('{4'b0000, 4'b0000, 10, 4'b0000, 0, 1});
    tbl.push_back('{4'b0010, 4'b0000,  2, 4'b0000, 0, 0});
    tbl.push_back('{4'b0000, 4'b0000,  2, 4'b0000, 0, 0});
    tbl.push_back('{4'b0010, 4'b0000,  2, 4'b0000, 0, 0});
    tbl.push_back('{4'b0000, 4'b0000,  2, 4'b0000, 0, 0});
    tbl.push_back('{4'b0010, 4'b0000,  8, 4'b0000, 1, 0});
    tbl.push_back('{4'b0000, 4'b0000, 10, 4'b0010, 0, 1});
    tbl.push_back('{4'b1000, 4'b0000,  8, 4'b0010, 1, 0});
    tbl.push_back('{4'b0000, 4'b0000, 10, 4'b1010, 0, 1});
    tbl.push_back('{4'b0000, 4'b1000,  2, 4'b0010, 0, 0});
    tbl.push_back('{4'b1000, 4'b1000,  8, 4'b1010, 1, 0});
    tbl.push_back('{4'b0000, 4'b1000, 10, 4'b0010, 0, 1});
    tbl.push_back('{4'b0000, 4'b0000,  2, 4'b1010, 0, 0});

    reset_and_check(4'b1111);
    reset_and_check(4'b0000);

    foreach (tbl[i]) begin
      sw = tbl[i].sw; mode = tbl[i].mode;
      npress = 0; nrel = 0;
      for (int c = 0; c < tbl[i].hold; c++) begin
        step();
        npress += $countones(press_p);
        nrel   += $countones(release_p);
      end
      chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
      chk($sformatf("tbl%0d_press_cnt", i), npress, tbl[i].exp_press);
      chk($sformatf("tbl%0d_release_cnt", i), nrel, tbl[i].exp_rel);
    end

    // Long press on ch2: flag timing, drop with release, no toggle.
    reset_and_check(4'b0000);
    mode = '0; sw = 4'b0100; got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step();
      if (press_p[2]) got = 1;
    end
    chk("long_press_pulse_seen", got, 1);
    cnt = 0; got = 0;
    for (int k = 0; k < 30 && got == 0; k++) begin
      step(); cnt++;
      if (long_p[2]) got = 1;
    end
    chk("long_rise_delay", cnt, LL + 1);
    repeat (8) step();
    sw = 4'b0000; got = 0; prev_long = int'(long_p[2]);
    for (int k = 0; k < 20 && got == 0; k++) begin
      prev_long = int'(long_p[2]);
      step();
      if (release_p[2]) got = 1;
    end
    chk("long_release_seen", got, 1);
    chk("long_high_before_release", prev_long, 1);
    chk("long_low_at_release", 32'(long_p[2]), 32'h0);
    chk("long_led_unchanged", 32'(led), 32'h0);

    // Reset in the middle of a hold: resynchronise with a single fresh press.
    sw = 4'b0100;
    repeat (15) step();
    reset_and_check(4'b0100);
    sw = 4'b0000;
    repeat (12) step();

    // Clear coincident with the ch0 release pulse.
    reset_and_check(4'b0000);
    sw = 4'b0100; repeat (8) step();
    sw = 4'b0000; repeat (10) step();
    sw = 4'b0001; repeat (8) step();
    sw = 4'b0000; got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      step();
      if (release_p[0]) got = 1;
    end
    chk("clear_release_seen", got, 1);
    chk("clear_led_before", 32'(led), 32'h5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_led_after", 32'(led), 32'h0);

    // Randomised activity: per-channel random hold lengths, occasional mode and clear changes.
    begin
      int rtimer[NUM_CH];
      for (int c = 0; c < NUM_CH; c++) rtimer[c] = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (rtimer[c] == 0) begin
            sw[c] = 1'($urandom_range(0, 1));
            rtimer[c] = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(4, 25));
          end else begin
            rtimer[c]--;
          end
        end
        if ((cyc % 200) == 0) mode = NUM_CH'($urandom_range(0, 15));
        clr = ($urandom_range(0, 63) == 0);
        step();
      end
      clr = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
